// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with its own
// instruction register, memory-wait timeouts, illegal-opcode trap and sticky halt/error.
module multicycle_control_unit #(
  parameter int WAIT_W   = 8,
  parameter int MAX_WAIT = 200,
  parameter int PCSRC_W  = 3
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic [31:0]        imemload,
  input  logic               ihit,
  input  logic               dhit,
  input  logic               alu_zf,
  output logic               iREN,
  output logic               dREN,
  output logic               dWEN,
  output logic               pc_en,
  output logic               ir_en,
  output logic               RegWr,
  output logic               MemToReg,
  output logic               RegDst,
  output logic               ALUSrc,
  output logic               ALUSrc2,
  output logic               ExtOp,
  output logic [3:0]         ALUctr,
  output logic [PCSRC_W-1:0] PCSrc,
  output logic [5:0]         opcode,
  output logic [5:0]         funct,
  output logic [4:0]         rs,
  output logic [4:0]         rt,
  output logic [4:0]         rd,
  output logic [4:0]         shamt,
  output logic [15:0]        immediate,
  output logic [25:0]        immediate26,
  output logic               halt,
  output logic               err,
  output logic [2:0]         state
);

  localparam logic [3:0] ALU_SLL = 4'd0, ALU_SRL = 4'd1, ALU_ADD = 4'd2, ALU_SUB = 4'd3,
                         ALU_AND = 4'd4, ALU_OR  = 4'd5, ALU_XOR = 4'd6, ALU_NOR = 4'd7,
                         ALU_SLT = 4'd8, ALU_SLTU = 4'd9, ALU_LUI = 4'd10;

  localparam logic [PCSRC_W-1:0] PC_SEQ = PCSRC_W'(0), PC_BR = PCSRC_W'(1),
                                 PC_JMP = PCSRC_W'(2), PC_REG = PCSRC_W'(3);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
    S_MEM  = 3'd4, S_WB    = 3'd5, S_HALT   = 3'd6, S_ERR  = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    C_ALU, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_JAL, C_JR, C_HALT, C_ILL
  } iclass_t;

  state_t            state_q, state_d;
  logic [31:0]       ir_q, ir_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  iclass_t    dec_cls;
  logic       dec_ext, dec_alu_src, dec_alu_src2, dec_reg_dst;
  logic [3:0] dec_alu_op;

  assign opcode      = ir_q[31:26];
  assign rs          = ir_q[25:21];
  assign rt          = ir_q[20:16];
  assign rd          = ir_q[15:11];
  assign shamt       = ir_q[10:6];
  assign funct       = ir_q[5:0];
  assign immediate   = ir_q[15:0];
  assign immediate26 = ir_q[25:0];
  assign state       = state_q;

  // NOTE: IR is reset (not left as plain storage) because its fields are outputs that must read 0 in IDLE.
  // NOTE: sequential state uses <= so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      wait_q  <= wait_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    dec_cls      = C_ILL;
    dec_ext      = 1'b0;
    dec_alu_src  = 1'b0;
    dec_alu_src2 = 1'b0;
    dec_reg_dst  = 1'b0;
    dec_alu_op   = ALU_ADD;
    case (opcode)
      6'h00: begin
        dec_cls     = C_ALU;
        dec_reg_dst = 1'b1;
        case (funct)
          6'h21: dec_alu_op = ALU_ADD;
          6'h23: dec_alu_op = ALU_SUB;
          6'h24: dec_alu_op = ALU_AND;
          6'h25: dec_alu_op = ALU_OR;
          6'h26: dec_alu_op = ALU_XOR;
          6'h27: dec_alu_op = ALU_NOR;
          6'h2A: dec_alu_op = ALU_SLT;
          6'h2B: dec_alu_op = ALU_SLTU;
          6'h00: begin dec_alu_op = ALU_SLL; dec_alu_src2 = 1'b1; end
          6'h02: begin dec_alu_op = ALU_SRL; dec_alu_src2 = 1'b1; end
          6'h08: dec_cls = C_JR;
          default: dec_cls = C_ILL;
        endcase
      end
      6'h02: dec_cls = C_J;
      6'h03: dec_cls = C_JAL;
      6'h04: begin dec_cls = C_BEQ; dec_ext = 1'b1; dec_alu_op = ALU_SUB; end
      6'h05: begin dec_cls = C_BNE; dec_ext = 1'b1; dec_alu_op = ALU_SUB; end
      6'h09: begin dec_cls = C_ALU; dec_ext = 1'b1; dec_alu_src = 1'b1; dec_alu_op = ALU_ADD;  end
      6'h0A: begin dec_cls = C_ALU; dec_ext = 1'b1; dec_alu_src = 1'b1; dec_alu_op = ALU_SLT;  end
      6'h0B: begin dec_cls = C_ALU; dec_ext = 1'b1; dec_alu_src = 1'b1; dec_alu_op = ALU_SLTU; end
      6'h0C: begin dec_cls = C_ALU; dec_alu_src = 1'b1; dec_alu_op = ALU_AND; end
      6'h0D: begin dec_cls = C_ALU; dec_alu_src = 1'b1; dec_alu_op = ALU_OR;  end
      6'h0E: begin dec_cls = C_ALU; dec_alu_src = 1'b1; dec_alu_op = ALU_XOR; end
      6'h0F: begin dec_cls = C_ALU; dec_alu_src = 1'b1; dec_alu_op = ALU_LUI; end
      6'h23: begin dec_cls = C_LW;  dec_ext = 1'b1; dec_alu_src = 1'b1; end
      6'h2B: begin dec_cls = C_SW;  dec_ext = 1'b1; dec_alu_src = 1'b1; end
      6'h3F: dec_cls = C_HALT;
      default: dec_cls = C_ILL;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    iREN     = 1'b0;
    dREN     = 1'b0;
    dWEN     = 1'b0;
    pc_en    = 1'b0;
    ir_en    = 1'b0;
    RegWr    = 1'b0;
    MemToReg = 1'b0;
    RegDst   = 1'b0;
    ALUSrc   = 1'b0;
    ALUSrc2  = 1'b0;
    ExtOp    = 1'b0;
    ALUctr   = 4'd0;
    PCSrc    = PC_SEQ;
    halt     = 1'b0;
    err      = 1'b0;

    // Datapath selects stay stable for the whole life of the decoded instruction.
    if (state_q inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
      ExtOp   = dec_ext;
      ALUSrc  = dec_alu_src;
      ALUSrc2 = dec_alu_src2;
      RegDst  = dec_reg_dst;
      ALUctr  = dec_alu_op;
    end

    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        iREN = 1'b1;
        if (ihit) begin
          ir_en   = 1'b1;
          ir_d    = imemload;
          state_d = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_ERR;
        end
      end
      S_DECODE: begin
        if (dec_cls == C_HALT)     state_d = S_HALT;
        else if (dec_cls == C_ILL) state_d = S_ERR;
        else                       state_d = S_EXEC;
      end
      S_EXEC: begin
        case (dec_cls)
          C_BEQ: begin PCSrc = alu_zf  ? PC_BR : PC_SEQ; pc_en = 1'b1; state_d = S_FETCH; end
          C_BNE: begin PCSrc = !alu_zf ? PC_BR : PC_SEQ; pc_en = 1'b1; state_d = S_FETCH; end
          C_J:   begin PCSrc = PC_JMP; pc_en = 1'b1; state_d = S_FETCH; end
          C_JR:  begin PCSrc = PC_REG; pc_en = 1'b1; state_d = S_FETCH; end
          C_JAL: begin PCSrc = PC_JMP; state_d = S_WB; end
          C_LW, C_SW: state_d = S_MEM;
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        dREN = (dec_cls == C_LW);
        dWEN = (dec_cls == C_SW);
        if (dhit) begin
          if (dec_cls == C_LW) begin
            state_d = S_WB;
          end else begin
            pc_en   = 1'b1;
            state_d = S_FETCH;
          end
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_ERR;
        end
      end
      S_WB: begin
        RegWr    = 1'b1;
        MemToReg = (dec_cls == C_LW);
        pc_en    = 1'b1;
        PCSrc    = (dec_cls == C_JAL) ? PC_JMP : PC_SEQ;
        state_d  = S_FETCH;
      end
      S_HALT: halt = 1'b1;
      S_ERR:  err  = 1'b1;
      default: state_d = S_IDLE;
    endcase

    // Wait counter saturates and restarts on every state change.
    if (state_d != state_q)
      wait_d = '0;
    else if ((state_q == S_FETCH || state_q == S_MEM) && wait_q != '1)
      wait_d = wait_q + 1'b1;
    else
      wait_d = wait_q;
  end

endmodule
